param_clock_divider: RTL and testbench
======================================

Name: param_clock_divider

Overview:
Parametrised, runtime-reprogrammable clock divider and tick generator for the counter datapath.
- Produces a divided square wave with programmable period and high time, in system-clock cycles, plus a one-cycle tick at each period boundary.
- New settings load through a valid/ready handshake and take effect only at a period boundary, so the output never glitches.
- Feeds the seconds counter and display-refresh logic.

Parameters:
CNT_W, 32, width of the period counter and configuration fields.
DEFAULT_PERIOD, 100000000, output period in clk_in cycles after reset; must be >= 2.
DEFAULT_HIGH, 50000000, high-phase length in cycles after reset; must satisfy 1 <= DEFAULT_HIGH <= DEFAULT_PERIOD-1.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
rst_n  input  1  synchronous, active-low reset.
en_in  input  1  count enable; 0 freezes the divider.
cfg_valid_in  input  1  new configuration offered.
cfg_ready_out  output  1  block can accept a configuration.
cfg_period_in  input  CNT_W  requested period in cycles.
cfg_high_in  input  CNT_W  requested high-phase length in cycles.
cfg_err_out  output  1  one-cycle pulse when an offered configuration is rejected.
divided_clk_out  output  1  divided square wave.
tick_out  output  1  one-cycle pulse at each period start.

Behaviour:
Reset
- Clock and reset: single clock domain (clk_in). rst_n is synchronous, active-low.
- While rst_n=0 at an edge:
  - count=0, active_period=DEFAULT_PERIOD, active_high=DEFAULT_HIGH.
  - Pending configuration cleared.
  - divided_clk_out=0, tick_out=0, cfg_err_out=0, cfg_ready_out=1.
- Reset mid-operation discards any pending configuration and restarts at count 0, low phase.

Counting
- When en_in=1, count advances by 1 per edge. At count=active_period-1 it wraps to 0 instead.
- All compares are unsigned, CNT_W wide.

Output phases
- divided_clk_out is registered. After each edge it equals (new count >= active_period - active_high).
- This gives a low phase first, then a high phase of exactly active_high cycles.
- tick_out=1 for exactly the cycle following a wrap edge; otherwise 0.
- A tick is never generated by reset or by a configuration applied while idle.

Enable low
- When en_in=0: count, divided_clk_out and active configuration are held, and tick_out=0.
- When en_in returns to 1, counting resumes from the held count, which stretches that period.

Configuration handshake
- A transfer occurs when cfg_valid_in=1 and cfg_ready_out=1 at an edge.
- Validity check: cfg_period_in >= 2 and 1 <= cfg_high_in <= cfg_period_in-1.
- Invalid transfer:
  - Rejected; cfg_err_out=1 for the next cycle only.
  - Active and pending configuration unchanged; cfg_ready_out stays 1.
- Valid transfer:
  - Stored as pending; cfg_ready_out=0 from the next cycle.
- Applying a pending configuration:
  - With en_in=1, it becomes active at the next wrap edge. The new period starts at count 0, evaluated with the new values.
  - With en_in=0, it is applied at the next edge: count<=0, divided_clk_out<=0, no tick.
  - cfg_ready_out returns to 1 in the cycle after the apply edge.
- Accept on the same edge as a wrap: the current wrap uses the old configuration, and the new one applies at the following wrap.
- cfg_*_in are ignored when cfg_ready_out=0.

Width and range
- Maximum period is 2^CNT_W-1.
- No internal arithmetic may overflow; compute thresholds in CNT_W bits from the validated values.

Test Plan:
1. DEFAULT_PERIOD=10, DEFAULT_HIGH=5, en_in=1 after reset -> divided_clk_out 0 for 5 cycles then 1 for 5, repeating; tick_out pulses every 10 cycles, first one 10 cycles after reset release.
2. Same defaults; at count 3 offer period=4, high=1 -> accepted, cfg_ready_out=0 until the wrap. The current 10-cycle period completes unchanged, then the pattern is 3 low / 1 high, ticks every 4 cycles, and cfg_ready_out returns to 1.
3. Offer period=1; then high=0; then period=6, high=6 -> each gives one cfg_err_out pulse, the waveform is unchanged, and cfg_ready_out stays 1 throughout.
4. Defaults; drop en_in for 7 cycles when count=6 -> divided_clk_out held at 1 and no ticks during the freeze; counting resumes at 6; that period measures 17 cycles.
5. Assert rst_n=0 for one edge during the high phase with a configuration pending -> next cycle divided_clk_out=0, tick_out=0, cfg_ready_out=1; the default pattern resumes and the pending configuration is never applied.
6. Offer period=4, high=2 on the exact wrap edge -> the following period still uses the old 10/5 values; the new 2-low/2-high pattern starts at the next wrap.

Source files
------------

// File: rtl/param_clock_divider.sv
// Programmable clock divider and tick generator.
// Produces a registered divided square wave (low phase first, then high phase)
// and a one-cycle tick after every period wrap. A new period/high pair is
// accepted through a valid/ready handshake. It becomes active only at a period
// boundary, or immediately while the divider is frozen, so the output never
// glitches.
module param_clock_divider #(
    parameter int unsigned      CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(100_000_000),
    parameter logic [CNT_W-1:0] DEFAULT_HIGH   = CNT_W'(50_000_000)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic             cfg_valid_in,
    output logic             cfg_ready_out,
    input  logic [CNT_W-1:0] cfg_period_in,
    input  logic [CNT_W-1:0] cfg_high_in,
    output logic             cfg_err_out,
    output logic             divided_clk_out,
    output logic             tick_out
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    // Period counter and the configuration currently shaping the waveform
    logic [CNT_W-1:0] count_q,         count_d;
    logic [CNT_W-1:0] active_period_q, active_period_d;
    logic [CNT_W-1:0] active_high_q,   active_high_d;

    // Accepted configuration waiting for the next period boundary
    logic             pend_valid_q,    pend_valid_d;
    logic [CNT_W-1:0] pend_period_q,   pend_period_d;
    logic [CNT_W-1:0] pend_high_q,     pend_high_d;

    // Registered outputs
    logic             div_q,           div_d;
    logic             tick_q,          tick_d;
    logic             err_q,           err_d;
    logic             ready_q,         ready_d;

    // Handshake and boundary qualifiers
    logic             xfer_c;
    logic             cfg_ok_c;
    logic             last_c;
    logic [CNT_W-1:0] thr_d;

    // Classify the offered configuration and detect the last count of a period
    always_comb begin
        xfer_c   = cfg_valid_in && ready_q;
        // high < period is high <= period-1 without the subtraction
        cfg_ok_c = (cfg_period_in >= TWO) &&
                   (cfg_high_in != '0) &&
                   (cfg_high_in < cfg_period_in);
        last_c   = (count_q == (active_period_q - ONE));
    end

    // Next-state logic: count, apply pending config, accept/reject offers
    always_comb begin
        count_d         = count_q;
        active_period_d = active_period_q;
        active_high_d   = active_high_q;
        pend_valid_d    = pend_valid_q;
        pend_period_d   = pend_period_q;
        pend_high_d     = pend_high_q;
        tick_d          = 1'b0;
        err_d           = 1'b0;

        if (en_in) begin
            if (last_c) begin
                // Wrap edge: the new period starts at 0 with any pending config
                count_d = '0;
                tick_d  = 1'b1;
                if (pend_valid_q) begin
                    active_period_d = pend_period_q;
                    active_high_d   = pend_high_q;
                    pend_valid_d    = 1'b0;
                end
            end else begin
                count_d = count_q + ONE;
            end
        end else if (pend_valid_q) begin
            // Frozen divider: apply at once, restart in the low phase, no tick
            count_d         = '0;
            active_period_d = pend_period_q;
            active_high_d   = pend_high_q;
            pend_valid_d    = 1'b0;
        end

        // Offers are only seen while nothing is pending, so this never
        // collides with the apply path above
        if (xfer_c) begin
            if (cfg_ok_c) begin
                pend_valid_d  = 1'b1;
                pend_period_d = cfg_period_in;
                pend_high_d   = cfg_high_in;
            end else begin
                err_d = 1'b1;
            end
        end

        // Threshold from validated values: period > high, so no underflow.
        // A frozen divider with nothing pending keeps its state, so this
        // also reproduces the held output level.
        thr_d   = active_period_d - active_high_d;
        div_d   = (count_d >= thr_d);
        ready_d = !pend_valid_d;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count_q         <= '0;
            active_period_q <= DEFAULT_PERIOD;
            active_high_q   <= DEFAULT_HIGH;
            pend_valid_q    <= 1'b0;
            pend_period_q   <= '0;
            pend_high_q     <= '0;
            div_q           <= 1'b0;
            tick_q          <= 1'b0;
            err_q           <= 1'b0;
            ready_q         <= 1'b1;
        end else begin
            count_q         <= count_d;
            active_period_q <= active_period_d;
            active_high_q   <= active_high_d;
            pend_valid_q    <= pend_valid_d;
            pend_period_q   <= pend_period_d;
            pend_high_q     <= pend_high_d;
            div_q           <= div_d;
            tick_q          <= tick_d;
            err_q           <= err_d;
            ready_q         <= ready_d;
        end
    end

    assign divided_clk_out = div_q;
    assign tick_out        = tick_q;
    assign cfg_err_out     = err_q;
    assign cfg_ready_out   = ready_q;

endmodule

// File: tb/tb_param_clock_divider.sv
// Directed bench for param_clock_divider built with a 10-cycle period and a
// 5-cycle high phase. Edge k counts rising edges after reset release; with
// those values, count = k mod 10 and the output is high for count >= 5.
module tb_param_clock_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         cfg_err;
    logic         div_clk;
    logic         tick;

    int tests_run    = 0;
    int tests_failed = 0;

    param_clock_divider #(
        .CNT_W         (W),
        .DEFAULT_PERIOD(W'(10)),
        .DEFAULT_HIGH  (W'(5))
    ) dut (
        .clk_in         (clk),
        .rst_n          (rst_n),
        .en_in          (en),
        .cfg_valid_in   (cfg_valid),
        .cfg_ready_out  (cfg_ready),
        .cfg_period_in  (cfg_period),
        .cfg_high_in    (cfg_high),
        .cfg_err_out    (cfg_err),
        .divided_clk_out(div_clk),
        .tick_out       (tick)
    );

    always #5 clk = ~clk;

    // One rising edge; inputs change and outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, then release with counting enabled
    task automatic do_reset();
        rst_n      = 1'b0;
        en         = 1'b1;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (div_clk !== 1'b0) begin tests_failed++; $display("FAIL reset_div got %b exp 0", div_clk); end
        tests_run++;
        if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got %b exp 0", tick); end
        tests_run++;
        if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b exp 0", cfg_err); end
        tests_run++;
        if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
    endtask

    // 5 low / 5 high, tick right after each wrap edge (k = 10, 20)
    task automatic test_default_pattern();
        logic ed, et;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            ed = ((k % 10) >= 5);
            et = ((k % 10) == 0);
            tests_run++;
            if (div_clk !== ed) begin tests_failed++; $display("FAIL default_div k=%0d got %b exp %b", k, div_clk, ed); end
            tests_run++;
            if (tick !== et) begin tests_failed++; $display("FAIL default_tick k=%0d got %b exp %b", k, tick, et); end
        end
    endtask

    // Offer 4/1 at count 3; current period finishes, then 3 low / 1 high
    task automatic test_reconfig();
        logic ed, et, er;
        int   c;
        do_reset();
        for (int k = 1; k <= 3; k++) step();
        cfg_valid  = 1'b1;
        cfg_period = W'(4);
        cfg_high   = W'(1);
        for (int k = 4; k <= 22; k++) begin
            step();
            cfg_valid = 1'b0;
            // Invalid offer while busy must be ignored (no err pulse at k=6)
            if (k == 5) begin
                cfg_valid  = 1'b1;
                cfg_period = W'(1);
                cfg_high   = W'(1);
            end
            if (k <= 10) begin
                ed = ((k % 10) >= 5);
                et = (k == 10);
            end else begin
                c  = (k - 10) % 4;
                ed = (c == 3);
                et = (c == 0);
            end
            er = (k >= 10);
            tests_run++;
            if (div_clk !== ed) begin tests_failed++; $display("FAIL reconfig_div k=%0d got %b exp %b", k, div_clk, ed); end
            tests_run++;
            if (tick !== et) begin tests_failed++; $display("FAIL reconfig_tick k=%0d got %b exp %b", k, tick, et); end
            tests_run++;
            if (cfg_ready !== er) begin tests_failed++; $display("FAIL reconfig_ready k=%0d got %b exp %b", k, cfg_ready, er); end
            tests_run++;
            if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reconfig_err k=%0d got %b exp 0", k, cfg_err); end
        end
    endtask

    // Three invalid offers: one err pulse each, waveform and ready untouched
    task automatic test_invalid_cfg();
        logic [W-1:0] pv [3];
        logic [W-1:0] hv [3];
        logic ed, et, ee;
        pv[0] = W'(1); hv[0] = W'(1);
        pv[1] = W'(8); hv[1] = W'(0);
        pv[2] = W'(6); hv[2] = W'(6);
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            step();
            cfg_valid = 1'b0;
            // Offers presented after edges 2, 5, 8 -> transfers at 3, 6, 9
            if (k == 2 || k == 5 || k == 8) begin
                cfg_valid  = 1'b1;
                cfg_period = pv[(k - 2) / 3];
                cfg_high   = hv[(k - 2) / 3];
            end
            ed = ((k % 10) >= 5);
            et = ((k % 10) == 0);
            ee = (k == 3 || k == 6 || k == 9);
            tests_run++;
            if (cfg_err !== ee) begin tests_failed++; $display("FAIL invalid_err k=%0d got %b exp %b", k, cfg_err, ee); end
            tests_run++;
            if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL invalid_ready k=%0d got %b exp 1", k, cfg_ready); end
            tests_run++;
            if (div_clk !== ed) begin tests_failed++; $display("FAIL invalid_div k=%0d got %b exp %b", k, div_clk, ed); end
            tests_run++;
            if (tick !== et) begin tests_failed++; $display("FAIL invalid_tick k=%0d got %b exp %b", k, tick, et); end
        end
    endtask

    // Freeze 7 edges at count 6: held high, no ticks, period stretches to 17
    task automatic test_enable_freeze();
        logic ed, et;
        do_reset();
        for (int k = 1; k <= 6; k++) step();
        en = 1'b0;
        for (int k = 7; k <= 18; k++) begin
            step();
            if (k == 13) en = 1'b1;
            ed = (k <= 16);
            et = (k == 17);
            tests_run++;
            if (div_clk !== ed) begin tests_failed++; $display("FAIL freeze_div k=%0d got %b exp %b", k, div_clk, ed); end
            tests_run++;
            if (tick !== et) begin tests_failed++; $display("FAIL freeze_tick k=%0d got %b exp %b", k, tick, et); end
        end
    endtask

    // Reset during high phase with 4/2 pending: pending config is discarded
    task automatic test_reset_pending();
        logic ed, et;
        do_reset();
        cfg_valid  = 1'b1;
        cfg_period = W'(4);
        cfg_high   = W'(2);
        step();
        cfg_valid = 1'b0;
        tests_run++;
        if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL rstpend_accept got %b exp 0", cfg_ready); end
        for (int k = 2; k <= 6; k++) step();
        tests_run++;
        if (div_clk !== 1'b1) begin tests_failed++; $display("FAIL rstpend_high got %b exp 1", div_clk); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run++;
        if (div_clk !== 1'b0) begin tests_failed++; $display("FAIL rstpend_div got %b exp 0", div_clk); end
        tests_run++;
        if (tick !== 1'b0) begin tests_failed++; $display("FAIL rstpend_tick got %b exp 0", tick); end
        tests_run++;
        if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL rstpend_ready got %b exp 1", cfg_ready); end
        for (int k = 1; k <= 20; k++) begin
            step();
            ed = ((k % 10) >= 5);
            et = ((k % 10) == 0);
            tests_run++;
            if (div_clk !== ed) begin tests_failed++; $display("FAIL rstpend_div k=%0d got %b exp %b", k, div_clk, ed); end
            tests_run++;
            if (tick !== et) begin tests_failed++; $display("FAIL rstpend_tick k=%0d got %b exp %b", k, tick, et); end
        end
    endtask

    // Offer 4/2 on the wrap edge: old 10/5 period runs once more first
    task automatic test_back_to_back();
        logic ed, et, er;
        int   c;
        do_reset();
        for (int k = 1; k <= 9; k++) step();
        cfg_valid  = 1'b1;
        cfg_period = W'(4);
        cfg_high   = W'(2);
        for (int k = 10; k <= 28; k++) begin
            step();
            cfg_valid = 1'b0;
            if (k <= 20) begin
                ed = ((k % 10) >= 5);
                et = ((k % 10) == 0);
            end else begin
                c  = (k - 20) % 4;
                ed = (c >= 2);
                et = (c == 0);
            end
            er = (k >= 20);
            tests_run++;
            if (div_clk !== ed) begin tests_failed++; $display("FAIL b2b_div k=%0d got %b exp %b", k, div_clk, ed); end
            tests_run++;
            if (tick !== et) begin tests_failed++; $display("FAIL b2b_tick k=%0d got %b exp %b", k, tick, et); end
            tests_run++;
            if (cfg_ready !== er) begin tests_failed++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, cfg_ready, er); end
        end
    endtask

    // Config pending while frozen applies at the next edge: count 0, low, no tick
    task automatic test_idle_apply();
        logic ed [9];
        logic et [9];
        // Edges 8..16 after the apply at edge 8 with 4/2 and resume at edge 10
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int k = 1; k <= 6; k++) step();
        cfg_valid  = 1'b1;
        cfg_period = W'(4);
        cfg_high   = W'(2);
        step();
        cfg_valid = 1'b0;
        en        = 1'b0;
        tests_run++;
        if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL idle_accept got %b exp 0", cfg_ready); end
        tests_run++;
        if (div_clk !== 1'b1) begin tests_failed++; $display("FAIL idle_prehigh got %b exp 1", div_clk); end
        for (int k = 8; k <= 16; k++) begin
            step();
            if (k == 9) en = 1'b1;
            tests_run++;
            if (div_clk !== ed[k-8]) begin tests_failed++; $display("FAIL idle_div k=%0d got %b exp %b", k, div_clk, ed[k-8]); end
            tests_run++;
            if (tick !== et[k-8]) begin tests_failed++; $display("FAIL idle_tick k=%0d got %b exp %b", k, tick, et[k-8]); end
            tests_run++;
            if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_ready k=%0d got %b exp 1", k, cfg_ready); end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        test_reset();
        test_default_pattern();
        test_reconfig();
        test_invalid_cfg();
        test_enable_freeze();
        test_reset_pending();
        test_back_to_back();
        test_idle_apply();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
